// File: rtl/antisat_key_loader.sv
// antisat_key_loader: serial key-delivery unit for Anti-SAT-locked netlists.
// Receives the secret key bit-serially (MSB first) over a valid/ready
// handshake and presents it in parallel once accepted. key_out stays all-zero
// until a complete accepted key exists.
//
// Optional feature macro: ANTISAT_KEY_PARITY_EN
//   defined   -> one extra even-parity bit per load, key_error reachable
//   undefined -> KEY_WIDTH bits per load, check always passes, key_error = 0
//
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   load_start   : pulse, begins a new load (abandons any load in progress)
//   zeroize      : synchronous key wipe, highest priority after reset
//   key_valid    : serial bit present
//   key_bit      : serial data bit
//   key_ready    : loader accepts a bit this cycle (state decode)
//   key_out      : parallel key to the locked core (keyIn_0_i <= key_out[i])
//   key_loaded   : key_out holds an accepted key
//   key_error    : last load failed its parity check
module antisat_key_loader #(
  parameter int unsigned KEY_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_start,
  input  logic                 zeroize,
  input  logic                 key_valid,
  input  logic                 key_bit,
  output logic                 key_ready,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 key_loaded,
  output logic                 key_error
);

  localparam int unsigned CNT_W = $clog2(KEY_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(KEY_WIDTH - 1);

`ifdef ANTISAT_KEY_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT  = 3'd1,
    PARITY = 3'd2,
    CHECK  = 3'd3,
    LOADED = 3'd4,
    ERROR  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT  = 3'd1,
    CHECK  = 3'd3,
    LOADED = 3'd4,
    ERROR  = 3'd5
  } state_t;
`endif

  state_t                 state_q, state_d;
  logic [KEY_WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [KEY_WIDTH-1:0]   key_out_q, key_out_d;
  logic                   loaded_q, loaded_d;
  logic                   accept_c;
  logic                   check_pass_c;
`ifdef ANTISAT_KEY_PARITY_EN
  logic                   par_q, par_d;
  logic                   error_q, error_d;
`endif

  // Ready is a pure state decode so the sender sees it without a register lag
`ifdef ANTISAT_KEY_PARITY_EN
  assign key_ready = (state_q == SHIFT) || (state_q == PARITY);
  assign check_pass_c = ((^{shreg_q, par_q}) == 1'b0);
`else
  assign key_ready = (state_q == SHIFT);
  assign check_pass_c = 1'b1;
`endif

  assign accept_c = key_valid && key_ready;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      key_out_q <= '0;
      loaded_q  <= 1'b0;
`ifdef ANTISAT_KEY_PARITY_EN
      par_q     <= 1'b0;
      error_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      key_out_q <= key_out_d;
      loaded_q  <= loaded_d;
`ifdef ANTISAT_KEY_PARITY_EN
      par_q     <= par_d;
      error_q   <= error_d;
`endif
    end
  end

  // Next-state and next-output logic; zeroize > load_start > handshake
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    key_out_d = key_out_q;
    loaded_d  = loaded_q;
`ifdef ANTISAT_KEY_PARITY_EN
    par_d     = par_q;
    error_d   = error_q;
`endif
    if (zeroize || load_start) begin
      state_d   = zeroize ? IDLE : SHIFT;
      shreg_d   = '0;
      cnt_d     = '0;
      key_out_d = '0;
      loaded_d  = 1'b0;
`ifdef ANTISAT_KEY_PARITY_EN
      par_d     = 1'b0;
      error_d   = 1'b0;
`endif
    end else begin
      unique case (state_q)
        SHIFT: begin
          if (accept_c) begin
            shreg_d = {shreg_q[KEY_WIDTH-2:0], key_bit};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_IDX) begin
`ifdef ANTISAT_KEY_PARITY_EN
              state_d = PARITY;
`else
              state_d = CHECK;
`endif
            end
          end
        end
`ifdef ANTISAT_KEY_PARITY_EN
        PARITY: begin
          if (accept_c) begin
            par_d   = key_bit;
            state_d = CHECK;
          end
        end
`endif
        CHECK: begin
          if (check_pass_c) begin
            key_out_d = shreg_q;
            loaded_d  = 1'b1;
            state_d   = LOADED;
          end else begin
`ifdef ANTISAT_KEY_PARITY_EN
            error_d = 1'b1;
`endif
            state_d = ERROR;
          end
        end
        default: ; // IDLE, LOADED, ERROR hold until load_start/zeroize
      endcase
    end
  end

  assign key_out    = key_out_q;
  assign key_loaded = loaded_q;
`ifdef ANTISAT_KEY_PARITY_EN
  assign key_error  = error_q;
`else
  assign key_error  = 1'b0;
`endif

endmodule
